// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, framing constants and helpers.
package uart_pkg;

  localparam int unsigned MIN_CPB_DEFAULT = 4;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      parity_err;
    logic                      frame_err;
  } rx_char_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Received-character write port toward the RX FIFO.
interface uart_rx_deframer_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_o;
  logic                      valid_o;
  logic                      parity_err_o;
  logic                      frame_err_o;
  logic                      break_o;

  modport master (output data_o, valid_o, parity_err_o, frame_err_o, break_o);
  modport slave  (input  data_o, valid_o, parity_err_o, frame_err_o, break_o);

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, reset value chosen per use.
module uart_sync_2ff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start detect, 3-point majority sampling, 8N1/8E1/8O1
// deframing with parity, framing and break status toward the RX FIFO.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned MIN_CPB = MIN_CPB_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [15:0]        clks_per_bit_i,
  input  logic               parity_en_i,
  input  logic               parity_odd_i,
  input  logic               rx_i,
  output logic               sbit_o,
  output logic               busy_o,
  uart_rx_deframer_if.master fifo_wr
);

  localparam logic [15:0] MinCpb = 16'(MIN_CPB);

  rx_state_e                 state_q;
  logic                      rx_s, rx_q;
  logic [15:0]               cpb_q, bcnt_q, half, cpb_lat;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      par_en_q, par_odd_q, perr_q, s0_q, s1_q;
  logic                      sbit_q, valid_q, brk_q;
  rx_char_t                  char_q;
  logic                      fall, smp, maj, stop_brk, start_ok;

  uart_sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // Bits are sampled from the history flop so the start boundary lines up
  // with T0 and the three samples sit symmetrically around the bit centre.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_q <= 1'b1;
    else         rx_q <= rx_s;
  end

  assign half     = cpb_q >> 1;
  assign fall     = rx_q & ~rx_s;
  assign smp      = (bcnt_q == half + 16'd1);
  assign maj      = maj3(s0_q, s1_q, rx_q);
  assign stop_brk = ~maj & (shift_q == '0);
  assign cpb_lat  = (clks_per_bit_i < MinCpb) ? MinCpb : clks_per_bit_i;

  // A start edge may also be taken in the stop-bit decision cycle, which is
  // what lets back-to-back frames through at the minimum divisor.
  assign start_ok = en_i & fall &
                    ((state_q == IDLE) | ((state_q == STOP) & smp & ~stop_brk));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cpb_q     <= '0;
      bcnt_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr_q    <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      sbit_q    <= 1'b0;
      valid_q   <= 1'b0;
      brk_q     <= 1'b0;
      char_q    <= '0;
    end else begin
      sbit_q  <= 1'b0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
      if (state_q != IDLE) begin
        bcnt_q <= (bcnt_q == cpb_q - 16'd1) ? '0 : bcnt_q + 16'd1;
        if (bcnt_q == half - 16'd1) s0_q <= rx_q;
        if (bcnt_q == half)         s1_q <= rx_q;
      end
      if (!en_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: ;
          START: if (smp) state_q <= maj ? IDLE : DATA;
          DATA: if (smp) begin
            shift_q <= {maj, shift_q[UART_DATA_BITS-1:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= par_en_q ? PARITY : STOP;
          end
          PARITY: if (smp) begin
            perr_q  <= ((^shift_q) ^ maj) != par_odd_q;
            state_q <= STOP;
          end
          STOP: if (smp) begin
            char_q  <= '{data: shift_q, parity_err: perr_q, frame_err: ~maj};
            valid_q <= 1'b1;
            if (stop_brk) begin
              brk_q   <= 1'b1;
              state_q <= BREAK_WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
          BREAK_WAIT: if (rx_s) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
        if (start_ok) begin
          sbit_q    <= 1'b1;
          cpb_q     <= cpb_lat;
          par_en_q  <= parity_en_i;
          par_odd_q <= parity_odd_i;
          bcnt_q    <= '0;
          bit_q     <= '0;
          perr_q    <= 1'b0;
          state_q   <= START;
        end
      end
    end
  end

  assign sbit_o               = sbit_q;
  assign busy_o               = (state_q != IDLE);
  assign fifo_wr.data_o       = char_q.data;
  assign fifo_wr.parity_err_o = char_q.parity_err;
  assign fifo_wr.frame_err_o  = char_q.frame_err;
  assign fifo_wr.valid_o      = valid_q;
  assign fifo_wr.break_o      = brk_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench: a serial driver pushes expected characters, a monitor checks FIFO writes.
module tb_uart_rx_deframer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] clks_per_bit_i = 16'd16;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        rx_i = 1'b1;
  logic        sbit_o, busy_o;

  uart_rx_deframer_if fifo ();

  uart_rx_deframer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .clks_per_bit_i (clks_per_bit_i),
    .parity_en_i    (parity_en_i),
    .parity_odd_i   (parity_odd_i),
    .rx_i           (rx_i),
    .sbit_o         (sbit_o),
    .busy_o         (busy_o),
    .fifo_wr        (fifo)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int mcyc = 0, last_t0 = 0, sbit_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Monitor: one observation per cycle, 1 time unit after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      mcyc++;
      if (fifo.valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data",       32'(fifo.data_o),       32'(e.data));
          chk("parity_err", 32'(fifo.parity_err_o), 32'(e.perr));
          chk("frame_err",  32'(fifo.frame_err_o),  32'(e.ferr));
          chk("break",      32'(fifo.break_o),      32'(e.brk));
          chk("latency",    32'(mcyc - last_t0),    32'(e.lat));
        end
      end else if (fifo.break_o === 1'b1) begin
        chk("stray_break", 32'd1, 32'd0);
      end
      if (sbit_o === 1'b1) begin
        last_t0 = mcyc;
        sbit_cnt++;
      end
    end
  end

  // Drives one character on the pin at the effective bit time and records
  // what the receiver must report for it.
  task automatic send(input logic [7:0] d, input int cpbp, input bit pen, input bit podd,
                      input bit flip, input bit stp, input int gap, input int tail_low,
                      input int abort_bit, input int glitch_bit);
    int   w, nb;
    logic frm[12];
    exp_t e;
    w  = (cpbp < 4) ? 4 : cpbp;
    nb = pen ? 11 : 10;
    frm[0] = 1'b0;
    for (int i = 0; i < 8; i++) frm[1+i] = d[i];
    if (pen) frm[9] = (^d) ^ podd ^ flip;
    frm[nb-1] = stp;
    clks_per_bit_i = 16'(cpbp);
    parity_en_i    = pen;
    parity_odd_i   = podd;
    if (abort_bit < 0) begin
      e.data = d;
      e.perr = pen & flip;
      e.ferr = ~stp;
      e.brk  = ~stp & (d == 8'h00);
      e.lat  = (9 + (pen ? 1 : 0)) * w + w / 2 + 2;
      exp_q.push_back(e);
    end
    for (int b = 0; b < nb; b++) begin
      if (b == abort_bit) en_i = 1'b0;
      for (int c = 0; c < w; c++) begin
        rx_i = (b == glitch_bit && c == w / 2) ? ~frm[b] : frm[b];
        if (b == abort_bit && c == 1) chk("abort_busy", 32'(busy_o), 32'd0);
        tick();
      end
    end
    if (tail_low > 0) begin
      rx_i = 1'b0;
      repeat (tail_low) tick();
    end
    if (gap > 0) begin
      rx_i = 1'b1;
      repeat (gap) tick();
    end
    if (abort_bit >= 0) en_i = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (busy_o === lvl) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: run exceeded cycle budget, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   n0;
    logic [7:0] d;
    int   cp, gap;
    bit   pen, podd, flip, stp;

    repeat (3) tick();
    chk("rst_data",  32'(fifo.data_o),       32'd0);
    chk("rst_valid", 32'(fifo.valid_o),      32'd0);
    chk("rst_perr",  32'(fifo.parity_err_o), 32'd0);
    chk("rst_ferr",  32'(fifo.frame_err_o),  32'd0);
    chk("rst_break", 32'(fifo.break_o),      32'd0);
    chk("rst_sbit",  32'(sbit_o),            32'd0);
    chk("rst_busy",  32'(busy_o),            32'd0);
    rst_ni = 1'b1;
    tick();
    en_i = 1'b1;
    repeat (5) tick();

    // 8N1 at 16 clocks per bit
    send(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 20, 0, -1, -1);

    // three-cycle low pulse is a false start
    n0 = sbit_cnt;
    rx_i = 1'b0;
    repeat (3) tick();
    rx_i = 1'b1;
    wait_busy(1'b1, 20, ok);
    chk("false_start_busy_rise", 32'(ok), 32'd1);
    wait_busy(1'b0, 40, ok);
    chk("false_start_busy_fall", 32'(ok), 32'd1);
    chk("false_start_fall_time", 32'(mcyc - last_t0), 32'd10);
    chk("false_start_sbit", 32'(sbit_cnt - n0), 32'd1);
    repeat (20) tick();

    // even parity: bad then good parity bit
    send(8'h0F, 16, 1'b1, 1'b0, 1'b1, 1'b1, 20, 0, -1, -1);
    send(8'h0F, 16, 1'b1, 1'b0, 1'b0, 1'b1, 20, 0, -1, -1);
    // odd parity, correct bit
    send(8'h81, 8, 1'b1, 1'b1, 1'b0, 1'b1, 20, 0, -1, -1);

    // one-cycle glitch in the middle of data bit 3
    send(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 20, 0, -1, 4);

    // break: line low for 12 bit times at 8 clocks per bit
    n0 = sbit_cnt;
    send(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16, -1, -1);
    chk("break_sbit_count", 32'(sbit_cnt - n0), 32'd1);
    chk("break_wait_busy", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    repeat (10) tick();
    chk("break_exit_busy", 32'(busy_o), 32'd0);
    chk("break_no_new_sbit", 32'(sbit_cnt - n0), 32'd1);
    send(8'h5C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 10, 0, -1, -1);

    // enable dropped during data bit 4, then a clean frame
    send(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 20, 0, 5, -1);
    chk("abort_data_held", 32'(fifo.data_o), 32'h5C);
    send(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 20, 0, -1, -1);
    // programmed divisor below the floor runs at the floor
    send(8'h3C, 2, 1'b0, 1'b0, 1'b0, 1'b1, 20, 0, -1, -1);
    // back-to-back at the minimum divisor
    send(8'hC3, 4, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, -1, -1);
    send(8'h7E, 4, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, -1, -1);
    send(8'h11, 3, 1'b0, 1'b0, 1'b0, 1'b1, 10, 0, -1, -1);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      cp   = $urandom_range(2, 12);
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      flip = pen & ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 7) != 0);
      if (stp) gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 20);
      else     gap = $urandom_range(3, 10);
      send(d, cp, pen, podd, flip, stp, gap, 0, -1, -1);
    end

    rx_i = 1'b1;
    repeat (60) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(busy_o), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
